// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ITERATIONS  = 4'd10;
  localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
  localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
  localparam logic [3:0] BCD_CORR        = 4'd3;

  function automatic logic is_bad_digit(input logic [3:0] digit);
    return digit > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
interface bcd_to_binary_if;
  logic       en;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [9:0] binary_value;
  logic       overflow;
  logic       invalid;
  logic       busy;
  logic       done;

  modport master (
    output en, start, hundreds, tens, ones,
    input  binary_value, overflow, invalid, busy, done
  );

  modport slave (
    input  en, start, hundreds, tens, ones,
    output binary_value, overflow, invalid, busy, done
  );
endinterface

// File: rtl/bcd_digit_correct.sv
// One reverse double-dabble correction: a nibble that picked up a bit from above is pulled back by 3.
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_CORR_THRESH) ? (digit_in - BCD_CORR) : digit_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 10-bit binary converter using ten reverse double-dabble iterations.
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  bcd_to_binary_if.slave bus
);

  state_t      state;
  logic [3:0]  iter_cnt;
  logic [21:0] work;
  logic [21:0] shifted;
  logic [21:0] next_work;
  logic [3:0]  hun_corr, ten_corr, one_corr;
  logic        digit_bad;

  logic [9:0]  binary_value_r;
  logic        overflow_r;
  logic        invalid_r;
  logic        busy_r;
  logic        done_r;

  assign shifted = work >> 1;

  bcd_digit_correct u_corr_hundreds (.digit_in(shifted[21:18]), .digit_out(hun_corr));
  bcd_digit_correct u_corr_tens     (.digit_in(shifted[17:14]), .digit_out(ten_corr));
  bcd_digit_correct u_corr_ones     (.digit_in(shifted[13:10]), .digit_out(one_corr));

  assign next_work = {hun_corr, ten_corr, one_corr, shifted[9:0]};

  // Before the first shift the work register still holds the raw captured digits.
  assign digit_bad = is_bad_digit(work[21:18]) || is_bad_digit(work[17:14]) ||
                     is_bad_digit(work[13:10]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      iter_cnt       <= 4'd0;
      work           <= 22'd0;
      binary_value_r <= 10'd0;
      overflow_r     <= 1'b0;
      invalid_r      <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work     <= {bus.hundreds, bus.tens, bus.ones, 10'd0};
            iter_cnt <= 4'd0;
            busy_r   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (iter_cnt == 4'd0 && digit_bad) begin
            binary_value_r <= 10'd0;
            overflow_r     <= 1'b0;
            invalid_r      <= 1'b1;
            done_r         <= 1'b1;
            busy_r         <= 1'b0;
            state          <= DONE;
          end else begin
            work <= next_work;
            if (iter_cnt == BCD_ITERATIONS - 4'd1) begin
              // The correction never touches the low 10 bits, so the shifted value is final.
              binary_value_r <= shifted[9:0];
              overflow_r     <= (shifted[9:0] > 10'd255);
              invalid_r      <= 1'b0;
              done_r         <= 1'b1;
              busy_r         <= 1'b0;
              iter_cnt       <= 4'd0;
              state          <= DONE;
            end else begin
              iter_cnt <= iter_cnt + 4'd1;
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.binary_value = binary_value_r;
  assign bus.overflow     = overflow_r;
  assign bus.invalid      = invalid_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: conversions, invalid digits, stalls, reset abort, ignored start.
module tb_bcd_to_binary;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bcd_to_binary_if bus ();

  bcd_to_binary dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents digits with start high for exactly one edge; returns just after that edge.
  task automatic run_start(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.hundreds = h;
    bus.tens     = t;
    bus.ones     = o;
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.en       = 1'b1;
    bus.start    = 1'b0;
    bus.hundreds = 4'd0;
    bus.tens     = 4'd0;
    bus.ones     = 4'd0;

    // Reset state
    step(2);
    check("rst_value", 32'(bus.binary_value), 32'd0);
    check("rst_ovf",   32'(bus.overflow),     32'd0);
    check("rst_inv",   32'(bus.invalid),      32'd0);
    check("rst_busy",  32'(bus.busy),         32'd0);
    check("rst_done",  32'(bus.done),         32'd0);
    reset = 1'b1;
    step(1);

    // 255: busy from edge k, result at edge k+10
    run_start(4'd2, 4'd5, 4'd5);
    check("c255_busy_k",  32'(bus.busy), 32'd1);
    check("c255_done_k",  32'(bus.done), 32'd0);
    step(9);
    check("c255_busy_k9", 32'(bus.busy), 32'd1);
    check("c255_done_k9", 32'(bus.done), 32'd0);
    step(1);
    check("c255_value",   32'(bus.binary_value), 32'd255);
    check("c255_ovf",     32'(bus.overflow),     32'd0);
    check("c255_inv",     32'(bus.invalid),      32'd0);
    check("c255_done",    32'(bus.done),         32'd1);
    check("c255_busy",    32'(bus.busy),         32'd0);
    step(1);
    check("c255_done_off", 32'(bus.done),         32'd0);
    check("c255_hold",     32'(bus.binary_value), 32'd255);

    // 999 overflows the 8-bit range
    run_start(4'd9, 4'd9, 4'd9);
    step(10);
    check("c999_value", 32'(bus.binary_value), 32'd999);
    check("c999_ovf",   32'(bus.overflow),     32'd1);
    check("c999_done",  32'(bus.done),         32'd1);
    step(1);

    // Invalid tens digit: done at k+1 with cleared result
    run_start(4'd1, 4'hA, 4'd3);
    check("inv_busy_k",  32'(bus.busy), 32'd1);
    check("inv_done_k",  32'(bus.done), 32'd0);
    step(1);
    check("inv_flag",    32'(bus.invalid),      32'd1);
    check("inv_value",   32'(bus.binary_value), 32'd0);
    check("inv_ovf",     32'(bus.overflow),     32'd0);
    check("inv_done",    32'(bus.done),         32'd1);
    check("inv_busy",    32'(bus.busy),         32'd0);
    step(1);
    check("inv_done_off", 32'(bus.done),    32'd0);
    check("inv_hold",     32'(bus.invalid), 32'd1);

    // 000 clears invalid
    run_start(4'd0, 4'd0, 4'd0);
    step(10);
    check("c000_value", 32'(bus.binary_value), 32'd0);
    check("c000_ovf",   32'(bus.overflow),     32'd0);
    check("c000_inv",   32'(bus.invalid),      32'd0);
    check("c000_done",  32'(bus.done),         32'd1);
    step(1);

    // 128 with a 3-cycle stall; inputs change mid-flight and must not matter
    run_start(4'd1, 4'd2, 4'd8);
    step(4);
    bus.en       = 1'b0;
    bus.hundreds = 4'd9;
    bus.tens     = 4'd9;
    bus.ones     = 4'd9;
    step(3);
    check("stall_busy",  32'(bus.busy),         32'd1);
    check("stall_done",  32'(bus.done),         32'd0);
    check("stall_value", 32'(bus.binary_value), 32'd0);
    bus.en = 1'b1;
    step(5);
    check("c128_done_k12", 32'(bus.done), 32'd0);
    step(1);
    check("c128_value", 32'(bus.binary_value), 32'd128);
    check("c128_ovf",   32'(bus.overflow),     32'd0);
    check("c128_done",  32'(bus.done),         32'd1);
    bus.en = 1'b0;
    step(2);
    check("c128_done_held", 32'(bus.done), 32'd1);
    bus.en = 1'b1;
    step(1);
    check("c128_done_off",  32'(bus.done), 32'd0);

    // Reset at k+5 aborts 456, then 042 starts on the first cycle after release
    run_start(4'd4, 4'd5, 4'd6);
    step(4);
    reset = 1'b0;
    step(1);
    check("abort_value", 32'(bus.binary_value), 32'd0);
    check("abort_busy",  32'(bus.busy),         32'd0);
    check("abort_done",  32'(bus.done),         32'd0);
    reset = 1'b1;
    run_start(4'd0, 4'd4, 4'd2);
    check("c042_busy_k", 32'(bus.busy), 32'd1);
    step(9);
    check("c042_done_k9", 32'(bus.done), 32'd0);
    step(1);
    check("c042_value", 32'(bus.binary_value), 32'd42);
    check("c042_done",  32'(bus.done),         32'd1);
    step(1);

    // Second start at k+3 with other digits is ignored
    run_start(4'd3, 4'd1, 4'd0);
    step(2);
    bus.hundreds = 4'd0;
    bus.tens     = 4'd0;
    bus.ones     = 4'd7;
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
    step(6);
    check("c310_done_k9", 32'(bus.done), 32'd0);
    step(1);
    check("c310_value", 32'(bus.binary_value), 32'd310);
    check("c310_ovf",   32'(bus.overflow),     32'd1);
    check("c310_done",  32'(bus.done),         32'd1);
    step(3);
    check("c310_no_requeue_busy", 32'(bus.busy), 32'd0);
    check("c310_no_requeue_done", 32'(bus.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
